// File: rtl/ifq.sv
// Instruction fetch queue: in-order {pc, inst} FIFO between fetch and decode.
// A taken jump flushes every buffered entry; ready toward fetch is purely registered.
module ifq #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         i_sys_clk,
   input  logic                         i_sys_rst_n,
   input  logic                         i_ifu_valid,
   output logic                         o_ifu_ready,
   input  logic [ADDR_WIDTH-1:0]        i_ifu_pc,
   input  logic [DATA_WIDTH-1:0]        i_ifu_inst,
   output logic                         o_idu_valid,
   input  logic                         i_idu_ready,
   output logic [ADDR_WIDTH-1:0]        o_idu_pc,
   output logic [DATA_WIDTH-1:0]        o_idu_inst,
   input  logic                         i_exu_jmp_en,
   output logic [$clog2(DEPTH):0]       o_ifq_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; ready never looks at the other side's ready, and a flush in the
   // same cycle discards the transfer.
   assign o_ifu_ready = (count != FULL_CNT);
   assign o_idu_valid = (count != '0);
   assign o_idu_pc    = pc_mem[rd_ptr];
   assign o_idu_inst  = inst_mem[rd_ptr];
   assign o_ifq_cnt   = count;

   assign push = i_ifu_valid & o_ifu_ready;
   assign pop  = o_idu_valid & i_idu_ready;

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (push && !i_exu_jmp_en) begin
         pc_mem[wr_ptr]   <= i_ifu_pc;
         inst_mem[wr_ptr] <= i_ifu_inst;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_exu_jmp_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq: reset, fill/stall, in-order drain, streaming wrap,
// flush priority and asynchronous mid-operation reset.
module tb_ifq;

  logic        clk;
  logic        rst_n;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        idu_valid;
  logic        idu_ready;
  logic [31:0] idu_pc;
  logic [31:0] idu_inst;
  logic        jmp_en;
  logic [2:0]  ifq_cnt;

  int n_cmp;
  int n_err;

  ifq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_ifu_valid  (ifu_valid),
    .o_ifu_ready  (ifu_ready),
    .i_ifu_pc     (ifu_pc),
    .i_ifu_inst   (ifu_inst),
    .o_idu_valid  (idu_valid),
    .i_idu_ready  (idu_ready),
    .o_idu_pc     (idu_pc),
    .o_idu_inst   (idu_inst),
    .i_exu_jmp_en (jmp_en),
    .o_ifq_cnt    (ifq_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change at the falling edge, outputs are checked there too
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [31:0] pc);
    ifu_valid = 1'b1;
    ifu_pc    = pc;
    ifu_inst  = inst_of(pc);
  endtask

  task automatic drive_idle();
    ifu_valid = 1'b0;
    ifu_pc    = '0;
    ifu_inst  = '0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    jmp_en    = 1'b0;
    idu_ready = 1'b0;
    drive_idle();

    // reset state
    #2;
    chk("rst_ready", ifu_ready, 1);
    chk("rst_valid", idu_valid, 0);
    chk("rst_cnt",   ifq_cnt, 0);
    chk("rst_pc",    idu_pc, 0);
    chk("rst_inst",  idu_inst, 0);
    tick();
    rst_n = 1'b1;

    // fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h8000_0000 + 32'(4 * i));
      tick();
      chk("fill_cnt",  ifq_cnt, i + 1);
      chk("fill_head", idu_pc, 32'h8000_0000);
      chk("fill_vld",  idu_valid, 1);
    end
    chk("full_ready", ifu_ready, 0);
    drive_push(32'h8000_0010);
    tick();
    chk("full_stall_cnt",  ifq_cnt, 4);
    chk("full_stall_head", idu_pc, 32'h8000_0000);
    chk("full_stall_inst", idu_inst, inst_of(32'h8000_0000));

    // drain in order
    drive_idle();
    idu_ready = 1'b1;
    tick();
    chk("pop_full_ready", ifu_ready, 1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc",   idu_pc, 32'h8000_0000 + 32'(4 * i));
      chk("drain_inst", idu_inst, inst_of(32'h8000_0000 + 32'(4 * i)));
      chk("drain_cnt",  ifq_cnt, 4 - i);
      tick();
    end
    chk("drain_empty_vld", idu_valid, 0);
    chk("drain_empty_cnt", ifq_cnt, 0);

    // streaming across pointer wrap: preload two, then push+pop each cycle
    idu_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_push(32'hA000_0000 + 32'(4 * i));
      tick();
    end
    idu_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", idu_pc, 32'hA000_0000 + 32'(4 * i));
      chk("stream_cnt",  ifq_cnt, 2);
      drive_push(32'hA000_0000 + 32'(4 * (i + 2)));
      tick();
    end
    drive_idle();
    chk("stream_tail0", idu_pc, 32'hA000_0028);
    tick();
    chk("stream_tail1", idu_pc, 32'hA000_002C);
    chk("stream_tail1_inst", idu_inst, inst_of(32'hA000_002C));
    tick();
    chk("stream_end_vld", idu_valid, 0);

    // flush with simultaneous push
    idu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(32'hB000_0000 + 32'(4 * i));
      tick();
    end
    chk("preflush_cnt", ifq_cnt, 3);
    jmp_en = 1'b1;
    drive_push(32'h9000_0000);
    tick();
    chk("flush_cnt",   ifq_cnt, 0);
    chk("flush_vld",   idu_valid, 0);
    chk("flush_ready", ifu_ready, 1);
    idu_ready = 1'b1;
    tick();
    chk("flush_hold_cnt", ifq_cnt, 0);
    chk("flush_hold_vld", idu_valid, 0);
    jmp_en    = 1'b0;
    idu_ready = 1'b0;
    tick();
    chk("postflush_vld",  idu_valid, 1);
    chk("postflush_head", idu_pc, 32'h9000_0000);
    chk("postflush_cnt",  ifq_cnt, 1);

    // asynchronous reset mid-operation
    drive_push(32'h9000_0004);
    tick();
    drive_idle();
    chk("premrst_cnt", ifq_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld",   idu_valid, 0);
    chk("mrst_cnt",   ifq_cnt, 0);
    chk("mrst_pc",    idu_pc, 0);
    chk("mrst_ready", ifu_ready, 1);
    tick();
    rst_n = 1'b1;
    drive_push(32'hC000_0000);
    tick();
    drive_idle();
    chk("afterrst_head", idu_pc, 32'hC000_0000);
    chk("afterrst_cnt",  ifq_cnt, 1);
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
